// File: rtl/tbird_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tbird_pkg
//  Brief    : Mode encoding and request-priority helper for the turn-signal
//             sequencer.
//  Revision : 1.0
// ============================================================================
package tbird_pkg;

    localparam int c_MODE_W = 2;

    typedef enum logic [c_MODE_W-1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

    // Simultaneous left and right is treated as a hazard request.
    function automatic mode_t req_mode(input logic l, input logic r, input logic h);
        mode_t m;
        m = MODE_IDLE;
        if (h || (l && r)) begin
            m = MODE_HAZARD;
        end else if (l) begin
            m = MODE_LEFT;
        end else if (r) begin
            m = MODE_RIGHT;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tbird_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Brief    : Free-running prescaler, one-cycle tick on terminal count DIV-1.
//  Revision : 1.0
// ============================================================================
module tick_gen #(
    parameter int DIV = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int                 c_CNT_W = $clog2(DIV);
    localparam logic [c_CNT_W-1:0] c_TERM  = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_TERM) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign tick = (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/tbird_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tbird_sequencer
//  Brief    : Thunderbird-style turn/hazard/brake lamp sequencer.
//  Revision : 1.0
// ============================================================================
module tbird_sequencer
    import tbird_pkg::*;
#(
    parameter int LAMPS_PER_SIDE = 3,
    parameter int TICK_DIV       = 12500000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        left,
    input  logic                        right,
    input  logic                        hazard,
    input  logic                        brake,
    output logic [2*LAMPS_PER_SIDE-1:0] lamp,
    output logic [c_MODE_W-1:0]         mode,
    output logic                        tick
);

    localparam int                    c_N        = LAMPS_PER_SIDE;
    localparam int                    c_LAMP_W   = 2 * LAMPS_PER_SIDE;
    localparam int                    c_STEP_W   = $clog2(LAMPS_PER_SIDE + 1);
    localparam logic [c_STEP_W-1:0]   c_STEP_MAX = c_STEP_W'(LAMPS_PER_SIDE);
    localparam logic [c_LAMP_W-1:0]   c_INACTIVE = {c_LAMP_W{ACTIVE_LOW}};

    // Synchronizer bit order: {brake, hazard, right, left}
    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;
    logic                w_tick;
    mode_t               w_req;
    mode_t               r_mode;
    mode_t               w_mode_nxt;
    logic [c_STEP_W-1:0] r_step;
    logic [c_STEP_W-1:0] w_step_nxt;
    logic [c_LAMP_W-1:0] r_lamp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {brake, hazard, right, left};
            r_sync2 <= r_sync1;
        end
    end

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_req = req_mode(r_sync2[0], r_sync2[1], r_sync2[2]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode <= MODE_IDLE;
            r_step <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            r_step <= w_step_nxt;
        end
    end

    // A mode change always restarts at step 0, so a direct side swap shows a dark frame.
    always_comb begin
        w_mode_nxt = r_mode;
        w_step_nxt = r_step;
        if (w_tick) begin
            if (w_req != r_mode) begin
                w_mode_nxt = w_req;
                w_step_nxt = '0;
            end else begin
                case (r_mode)
                    MODE_LEFT, MODE_RIGHT:
                        w_step_nxt = (r_step == c_STEP_MAX) ? '0 : r_step + c_STEP_W'(1);
                    MODE_HAZARD:
                        w_step_nxt = r_step ^ c_STEP_W'(1);
                    default:
                        w_step_nxt = '0;
                endcase
            end
        end
    end

    // Index 0 of the sequence mask is the innermost lamp of a side.
    function automatic logic [c_LAMP_W-1:0] pattern(
        input mode_t               m,
        input logic [c_STEP_W-1:0] s,
        input logic                b
    );
        logic [c_N-1:0]      seq;
        logic [c_N-1:0]      rseq;
        logic [c_N-1:0]      side_b;
        logic [c_LAMP_W-1:0] p;
        side_b = {c_N{b}};
        for (int i = 0; i < c_N; i++) begin
            seq[i]           = (i < int'(s));
            rseq[c_N-1-i]    = (i < int'(s));
        end
        case (m)
            MODE_LEFT:   p = {seq, side_b};
            MODE_RIGHT:  p = {side_b, rseq};
            MODE_HAZARD: p = {c_LAMP_W{s[0]}};
            default:     p = {c_LAMP_W{b}};
        endcase
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lamp <= c_INACTIVE;
        end else begin
            r_lamp <= pattern(r_mode, r_step, r_sync2[3]) ^ c_INACTIVE;
        end
    end

    assign lamp = r_lamp;
    assign mode = r_mode;
    assign tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_tbird_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tbird_sequencer
//  Brief    : Directed self-checking bench, N=3, TICK_DIV=4, active-high lamps.
//  Revision : 1.0
// ============================================================================
module tb_tbird_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       left;
    logic       right;
    logic       hazard;
    logic       brake;
    logic [5:0] lamp;
    logic [1:0] mode;
    logic       tick;

    int n_checks = 0;
    int n_pass   = 0;

    tbird_sequencer #(
        .LAMPS_PER_SIDE (3),
        .TICK_DIV       (4),
        .ACTIVE_LOW     (1'b0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .left   (left),
        .right  (right),
        .hazard (hazard),
        .brake  (brake),
        .lamp   (lamp),
        .mode   (mode),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        @(negedge clk);
        while (tick !== 1'b1 && k < 16) begin
            @(negedge clk);
            k++;
        end
        if (tick !== 1'b1) begin
            check("tick_timeout", {7'b0, tick}, 8'd1);
        end
    endtask

    // Lamp reflects a tick's mode/step update two edges after the tick cycle.
    task automatic tick_lamp(input string tag, input logic [5:0] exp);
        wait_tick();
        @(negedge clk);
        @(negedge clk);
        check(tag, {2'b0, lamp}, {2'b0, exp});
    endtask

    initial begin
        rst_n  = 1'b0;
        left   = 1'b1;
        right  = 1'b0;
        hazard = 1'b0;
        brake  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lamp", {2'b0, lamp}, 8'h00);
        check("rst_mode", {6'b0, mode}, 8'd0);
        check("rst_tick", {7'b0, tick}, 8'd0);
        rst_n = 1'b1;

        tick_lamp("left_s0", 6'b000000);
        tick_lamp("left_s1", 6'b001000);
        tick_lamp("left_s2", 6'b011000);
        tick_lamp("left_s3", 6'b111000);
        tick_lamp("left_wrap", 6'b000000);
        tick_lamp("left_s1b", 6'b001000);
        check("left_mode", {6'b0, mode}, 8'd1);
        tick_lamp("left_s2b", 6'b011000);

        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_lamp", {2'b0, lamp}, 8'h00);
        check("midrst_mode", {6'b0, mode}, 8'd0);
        check("midrst_tick", {7'b0, tick}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_tick1", {7'b0, tick}, 8'd0);
        @(negedge clk);
        check("rel_tick2", {7'b0, tick}, 8'd0);
        @(negedge clk);
        check("rel_tick3", {7'b0, tick}, 8'd1);
        @(negedge clk);
        check("tick_pulse", {7'b0, tick}, 8'd0);
        @(negedge clk);
        check("rel_lamp0", {2'b0, lamp}, 8'h00);
        tick_lamp("rel_s1", 6'b001000);
        tick_lamp("rel_s2", 6'b011000);

        left  = 1'b0;
        right = 1'b1;
        tick_lamp("swap_s0", 6'b000000);
        check("swap_mode", {6'b0, mode}, 8'd2);
        tick_lamp("swap_s1", 6'b000100);

        right = 1'b0;
        tick_lamp("idle", 6'b000000);
        check("idle_mode", {6'b0, mode}, 8'd0);
        brake = 1'b1;
        @(negedge clk);
        check("brake_c1", {2'b0, lamp}, 8'h00);
        @(negedge clk);
        check("brake_c2", {2'b0, lamp}, 8'h00);
        @(negedge clk);
        check("brake_c3", {2'b0, lamp}, 8'h3f);
        tick_lamp("brake_hold", 6'b111111);

        right = 1'b1;
        tick_lamp("rbrk_s0", 6'b111000);
        tick_lamp("rbrk_s1", 6'b111100);
        tick_lamp("rbrk_s2", 6'b111110);
        tick_lamp("rbrk_s3", 6'b111111);
        tick_lamp("rbrk_wrap", 6'b111000);
        check("rbrk_mode", {6'b0, mode}, 8'd2);

        left = 1'b1;
        tick_lamp("haz_0", 6'b000000);
        check("haz_mode", {6'b0, mode}, 8'd3);
        tick_lamp("haz_1", 6'b111111);
        brake = 1'b0;
        tick_lamp("haz_2", 6'b000000);
        tick_lamp("haz_3", 6'b111111);
        brake = 1'b1;
        tick_lamp("haz_4", 6'b000000);

        brake = 1'b0;
        right = 1'b0;
        tick_lamp("abort_s0", 6'b000000);
        tick_lamp("abort_s1", 6'b001000);
        tick_lamp("abort_s2", 6'b011000);
        left = 1'b0;
        tick_lamp("abort_off", 6'b000000);
        check("abort_mode", {6'b0, mode}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tbird_sequencer.md
TBIRD_SEQUENCER -- requirements
Module: tbird_sequencer

Interface
REQ-001 Parameter LAMPS_PER_SIDE, default 3, lamps per side (N), legal 2..8.
REQ-002 Parameter TICK_DIV, default 12500000, clk cycles per sequence step, legal 2..2^26.
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = lamp outputs inverted for active-low display drive.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 left  input  1  left-turn request, asynchronous switch.
REQ-007 right  input  1  right-turn request, asynchronous switch.
REQ-008 hazard  input  1  hazard request, asynchronous switch.
REQ-009 brake  input  1  brake request, asynchronous switch.
REQ-010 lamp  output  2N  registered lamp drive; [2N-1:N] left side, bit N innermost; [N-1:0] right side, bit N-1 innermost.
REQ-011 mode  output  2  registered current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
REQ-012 tick  output  1  one-cycle pulse on the prescaler terminal count.

Function
REQ-013 Each of left/right/hazard/brake SHALL pass a 2-flop synchronizer; only synchronized values are used.
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick = 1 in the cycle the count equals TICK_DIV-1.
REQ-015 Requested mode: HAZARD if hazard or (left and right); else LEFT if left; else RIGHT if right; else IDLE.
REQ-016 mode and step (0..N) SHALL change only in tick cycles.
REQ-017 On tick with requested mode != mode: mode <= requested, step <= 0.
REQ-018 On tick with requested mode == mode: LEFT/RIGHT step <= (step==N) ? 0 : step+1; HAZARD step <= step ^ 1 (0/1 only); IDLE step <= 0.
REQ-019 Sequenced side in LEFT/RIGHT: innermost `step` lamps lit, others off; step 0 = side off.
REQ-020 Non-sequenced side in LEFT/RIGHT: all on if brake, else all off.
REQ-021 IDLE: all 2N lamps on if brake, else all off.
REQ-022 HAZARD: all 2N lamps on when step==1, all off when step==0; brake ignored.
REQ-023 lamp SHALL be registered from the current mode, step and synced brake, then XOR-inverted when ACTIVE_LOW=1.
REQ-024 Brake latency: input edge to lamp change = 3 clk cycles (2 sync + output register) when not in HAZARD.
REQ-025 Mode-change latency: first tick at least 2 cycles after the input edge updates mode/step; lamp reflects it one cycle later.
REQ-026 Request withdrawn mid-sequence SHALL abort at the next tick (step 0, IDLE pattern); no sequence completion.
REQ-027 Direct LEFT<->RIGHT switch at one tick SHALL pass through step 0 (all off on the new side).

Reset
REQ-028 While rst_n=0 at a clk edge: prescaler 0, sync flops 0, mode IDLE, step 0, tick 0, lamp all-inactive (all 1s if ACTIVE_LOW=1, else all 0s).
REQ-029 Reset mid-sequence SHALL take effect on the same edge; the first tick after release occurs TICK_DIV cycles later.

Structure
REQ-030 Package tbird_pkg SHALL hold the mode encoding (IDLE/LEFT/RIGHT/HAZARD) and the 2-bit mode width constant.
REQ-031 Prescaler SHALL be a sub-module tick_gen (params DIV; ports clk, rst_n, tick); width = clog2(DIV).
REQ-032 Pattern generation SHALL be one combinational function of (mode, step, brake) feeding the lamp register.

Verification (N=3, TICK_DIV=4, ACTIVE_LOW=0)
REQ-033 Hold left=1 from reset -> lamp per tick: 000000, 001000, 011000, 111000, 000000, 001000; mode=1.
REQ-034 Hold right=1 and brake=1 -> lamp per tick: 111000, 111100, 111110, 111111, 111000.
REQ-035 left=1 and right=1 together -> mode=3; lamp alternates 000000/111111 each tick; toggling brake changes nothing.
REQ-036 Idle, brake 0->1 -> lamp becomes 111111 exactly 3 cycles later, independent of tick.
REQ-037 left sequencing at 011000, then rst_n=0 one cycle -> lamp 000000, mode 0 next edge; tick first reasserts 4 cycles after release.
REQ-038 Left at step 2, switch to right -> next tick lamp 000000, mode=2, following tick 000100.
